hello_sequencer: RTL

HELLO_SEQUENCER -- requirements
Module: hello_sequencer

---
 rtl/hello_sequencer.sv | 77 +++++++
 1 files changed

// File: rtl/hello_sequencer.sv
// hello_sequencer: steps a 3-bit letter register through H,E,L,L,O with one Load strobe per letter change.
// Ports: Clk clock, Clr sync active-high reset, Start begin pass, Stop abort to idle,
//        Hold freeze tick/letter, T letter code, Load register strobe, Busy not idle, Done pass complete.
// Build option: define HELLO_LOOP_EN to restart at H after O instead of returning to idle.
module hello_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Hold,
    output logic [2:0] T,
    output logic       Load,
    output logic       Busy,
    output logic       Done
);
    typedef enum logic [2:0] {IDLE, S_H, S_E, S_L1, S_L2, S_O} state_t;
    localparam logic [7:0] RELOAD = 8'(TICK_DIV - 1);
    localparam logic [2:0] BLANK = 3'b111;
    state_t state;
    logic [7:0] tick;
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state <= IDLE;
            tick  <= 8'd0;
            T     <= BLANK;
            Load  <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Load <= 1'b0;
            Done <= 1'b0;
            if (state == IDLE) begin
                if (Start && !Stop) begin
                    state <= S_H;
                    T     <= 3'b000;
                    Load  <= 1'b1;
                    Busy  <= 1'b1;
                    tick  <= RELOAD;
                end
            end else if (Stop) begin
                // abort wins over Hold and over a same-cycle tick expiry
                state <= IDLE;
                T     <= BLANK;
                Load  <= 1'b1;
                Busy  <= 1'b0;
                tick  <= 8'd0;
            end else if (!Hold) begin
                if (tick != 8'd0) begin
                    tick <= tick - 8'd1;
                end else begin
                    tick <= RELOAD;
                    Load <= 1'b1;
                    case (state)
                        S_H:  begin state <= S_E;  T <= 3'b001; end
                        S_E:  begin state <= S_L1; T <= 3'b010; end
                        S_L1: begin state <= S_L2; T <= 3'b010; end
                        S_L2: begin state <= S_O;  T <= 3'b011; end
                        default: begin
                            Done <= 1'b1;
`ifdef HELLO_LOOP_EN
                            state <= S_H;
                            T     <= 3'b000;
`else
                            state <= IDLE;
                            T     <= BLANK;
                            Busy  <= 1'b0;
                            tick  <= 8'd0;
`endif
                        end
                    endcase
                end
            end
        end
    end
endmodule
